// File: rtl/wb_regfile_hilo.sv
// Write-back register file: 32 GPRs plus HI/LO, committed on the clock edge.
// Read ports bypass the in-flight write so ID needs no WB forwarding path.
module wb_regfile_hilo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              cpu_clk_75M,
  input  logic              cpu_rst_n,
  input  logic [ADDR_W-1:0] wb_wd,
  input  logic              wb_wreg,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              wb_whilo,
  input  logic [DATA_W-1:0] wb_hi,
  input  logic [DATA_W-1:0] wb_lo,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              dbg_wen,
  output logic [ADDR_W-1:0] dbg_wnum,
  output logic [DATA_W-1:0] dbg_wdata
);

  logic [DATA_W-1:0] gpr_q [NREG];
  logic [DATA_W-1:0] gpr_d [NREG];
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              dbg_wen_q, dbg_wen_d;
  logic [ADDR_W-1:0] dbg_wnum_q, dbg_wnum_d;
  logic [DATA_W-1:0] dbg_wdata_q, dbg_wdata_d;
  logic              wr_en;

  // $0 is hardwired: a write aimed at it is dropped
  assign wr_en = wb_wreg && (wb_wd != '0);

  always_comb begin
    gpr_d = gpr_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (wr_en) gpr_d[wb_wd] = wb_wdata;
    if (wb_whilo) begin
      hi_d = wb_hi;
      lo_d = wb_lo;
    end
    dbg_wen_d   = wr_en;
    dbg_wnum_d  = wb_wd;
    dbg_wdata_d = wb_wdata;
  end

  always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      dbg_wen_q   <= 1'b0;
      dbg_wnum_q  <= '0;
      dbg_wdata_q <= '0;
    end else begin
      gpr_q       <= gpr_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      dbg_wen_q   <= dbg_wen_d;
      dbg_wnum_q  <= dbg_wnum_d;
      dbg_wdata_q <= dbg_wdata_d;
    end
  end

  always_comb begin
    rdata1 = '0;
    if (!cpu_rst_n || !re1 || raddr1 == '0)
      rdata1 = '0;
    else if (wb_wreg && wb_wd == raddr1)
      rdata1 = wb_wdata;
    else
      rdata1 = gpr_q[raddr1];
  end

  always_comb begin
    rdata2 = '0;
    if (!cpu_rst_n || !re2 || raddr2 == '0)
      rdata2 = '0;
    else if (wb_wreg && wb_wd == raddr2)
      rdata2 = wb_wdata;
    else
      rdata2 = gpr_q[raddr2];
  end

  always_comb begin
    hi_o = '0;
    lo_o = '0;
    if (!cpu_rst_n) begin
      hi_o = '0;
      lo_o = '0;
    end else if (wb_whilo) begin
      hi_o = wb_hi;
      lo_o = wb_lo;
    end else begin
      hi_o = hi_q;
      lo_o = lo_q;
    end
  end

  assign dbg_wen   = dbg_wen_q;
  assign dbg_wnum  = dbg_wnum_q;
  assign dbg_wdata = dbg_wdata_q;

endmodule

// File: tb/tb_wb_regfile_hilo.sv
// Scoreboarded random + directed bench for wb_regfile_hilo.
// Driver pushes expected outputs; monitor compares each cycle.
module tb_wb_regfile_hilo;

  logic        cpu_clk_75M = 1'b0;
  logic        cpu_rst_n = 1'b0;
  logic [4:0]  wb_wd = '0;
  logic        wb_wreg = 1'b0;
  logic [31:0] wb_wdata = '0;
  logic        wb_whilo = 1'b0;
  logic [31:0] wb_hi = '0;
  logic [31:0] wb_lo = '0;
  logic        re1 = 1'b0;
  logic [4:0]  raddr1 = '0;
  logic [31:0] rdata1;
  logic        re2 = 1'b0;
  logic [4:0]  raddr2 = '0;
  logic [31:0] rdata2;
  logic [31:0] hi_o, lo_o;
  logic        dbg_wen;
  logic [4:0]  dbg_wnum;
  logic [31:0] dbg_wdata;

  always #5 cpu_clk_75M = ~cpu_clk_75M;

  wb_regfile_hilo dut (
    .cpu_clk_75M(cpu_clk_75M), .cpu_rst_n(cpu_rst_n),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .hi_o(hi_o), .lo_o(lo_o),
    .dbg_wen(dbg_wen), .dbg_wnum(dbg_wnum), .dbg_wdata(dbg_wdata)
  );

  typedef struct {
    logic        rst_n;
    logic        wreg;
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        re1;
    logic [4:0]  ra1;
    logic        re2;
    logic [4:0]  ra2;
  } stim_t;

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dwen;
    logic [4:0]  dwnum;
    logic [31:0] dwdata;
  } exp_t;

  exp_t expq[$];
  int total = 0;
  int bad = 0;

  // reference state: architectural view of the register file
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_dwen = 1'b0;
  logic [4:0]  m_dwnum = '0;
  logic [31:0] m_dwdata = '0;

  initial for (int i = 0; i < 32; i++) m_gpr[i] = '0;

  function automatic logic [31:0] m_read(stim_t s, logic re,
                                         logic [4:0] a);
    if (!s.rst_n || !re || a == 5'd0) return 32'd0;
    if (s.wreg && s.wd == a) return s.wdata;
    return m_gpr[a];
  endfunction

  function automatic stim_t bubble();
    stim_t s;
    s.rst_n = 1'b1; s.wreg = 1'b0; s.wd = '0; s.wdata = '0;
    s.whilo = 1'b0; s.hi = '0; s.lo = '0;
    s.re1 = 1'b0; s.ra1 = '0; s.re2 = 1'b0; s.ra2 = '0;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.rst_n = 1'b1;
    s.wreg  = 1'($urandom_range(0, 1));
    s.wd    = 5'($urandom_range(0, 31));
    s.wdata = $urandom;
    s.whilo = ($urandom_range(0, 3) == 0);
    s.hi    = $urandom;
    s.lo    = $urandom;
    s.re1   = ($urandom_range(0, 4) != 0);
    s.ra1   = ($urandom_range(0, 2) == 0) ? s.wd
                                          : 5'($urandom_range(0, 31));
    s.re2   = ($urandom_range(0, 4) != 0);
    s.ra2   = ($urandom_range(0, 2) == 0) ? s.ra1
                                          : 5'($urandom_range(0, 31));
    return s;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    @(negedge cpu_clk_75M);
    cpu_rst_n = s.rst_n;
    wb_wreg = s.wreg; wb_wd = s.wd; wb_wdata = s.wdata;
    wb_whilo = s.whilo; wb_hi = s.hi; wb_lo = s.lo;
    re1 = s.re1; raddr1 = s.ra1; re2 = s.re2; raddr2 = s.ra2;
    e.rd1    = m_read(s, s.re1, s.ra1);
    e.rd2    = m_read(s, s.re2, s.ra2);
    e.hi     = !s.rst_n ? 32'd0 : (s.whilo ? s.hi : m_hi);
    e.lo     = !s.rst_n ? 32'd0 : (s.whilo ? s.lo : m_lo);
    e.dwen   = s.rst_n ? m_dwen : 1'b0;
    e.dwnum  = s.rst_n ? m_dwnum : 5'd0;
    e.dwdata = s.rst_n ? m_dwdata : 32'd0;
    expq.push_back(e);
    // state seen after the coming rising edge
    if (!s.rst_n) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = '0;
      m_hi = '0; m_lo = '0;
      m_dwen = 1'b0; m_dwnum = '0; m_dwdata = '0;
    end else begin
      if (s.wreg && s.wd != 5'd0) m_gpr[s.wd] = s.wdata;
      if (s.whilo) begin
        m_hi = s.hi;
        m_lo = s.lo;
      end
      m_dwen   = s.wreg && (s.wd != 5'd0);
      m_dwnum  = s.wd;
      m_dwdata = s.wdata;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge cpu_clk_75M);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("rdata1", rdata1, e.rd1);
        chk("rdata2", rdata2, e.rd2);
        chk("hi_o", hi_o, e.hi);
        chk("lo_o", lo_o, e.lo);
        chk("dbg_wen", {31'd0, dbg_wen}, {31'd0, e.dwen});
        chk("dbg_wnum", {27'd0, dbg_wnum}, {27'd0, e.dwnum});
        chk("dbg_wdata", dbg_wdata, e.dwdata);
      end
    end
  end

  initial begin : driver
    stim_t s;
    // reset held with a live read request
    s = bubble(); s.rst_n = 1'b0; s.re1 = 1'b1; s.ra1 = 5'd5;
    s.whilo = 1'b1; s.hi = 32'h1; s.lo = 32'h2;
    apply(s);
    apply(s);
    for (int i = 0; i < 32; i++) begin
      s = bubble(); s.re1 = 1'b1; s.ra1 = 5'(i);
      s.re2 = 1'b1; s.ra2 = 5'(31 - i);
      apply(s);
    end
    // write r7 then read it back and watch the trace
    s = bubble(); s.wreg = 1'b1; s.wd = 5'd7; s.wdata = 32'hDEADBEEF;
    apply(s);
    s = bubble(); s.re1 = 1'b1; s.ra1 = 5'd7;
    apply(s);
    apply(s);
    // $0 stays zero
    s = bubble(); s.wreg = 1'b1; s.wd = 5'd0; s.wdata = 32'hFFFFFFFF;
    s.re2 = 1'b1; s.ra2 = 5'd0;
    apply(s);
    s.wreg = 1'b0;
    apply(s);
    // bypass against an older stored value
    s = bubble(); s.wreg = 1'b1; s.wd = 5'd3; s.wdata = 32'h11;
    apply(s);
    s = bubble(); s.wreg = 1'b1; s.wd = 5'd3; s.wdata = 32'h22;
    s.re1 = 1'b1; s.ra1 = 5'd3; s.re2 = 1'b0; s.ra2 = 5'd3;
    apply(s);
    s = bubble(); s.re1 = 1'b1; s.ra1 = 5'd3; s.re2 = 1'b1; s.ra2 = 5'd3;
    apply(s);
    // HI/LO alongside a GPR write
    s = bubble(); s.whilo = 1'b1; s.hi = 32'hA; s.lo = 32'hB;
    s.wreg = 1'b1; s.wd = 5'd9; s.wdata = 32'h99;
    apply(s);
    s = bubble(); s.re1 = 1'b1; s.ra1 = 5'd9;
    apply(s);
    // randomized traffic with occasional reset pulses
    for (int n = 0; n < 400; n++) begin
      s = rnd();
      if ($urandom_range(0, 59) == 0) s.rst_n = 1'b0;
      apply(s);
    end
    // fill r1..r31 and HI/LO, then reset mid-stream
    for (int i = 1; i < 32; i++) begin
      s = bubble(); s.wreg = 1'b1; s.wd = 5'(i); s.wdata = $urandom | 32'h1;
      s.whilo = (i == 31); s.hi = 32'hCAFE; s.lo = 32'hF00D;
      s.re1 = 1'b1; s.ra1 = 5'(i - 1);
      apply(s);
    end
    s = bubble(); s.rst_n = 1'b0; s.re1 = 1'b1; s.ra1 = 5'd17;
    s.re2 = 1'b1; s.ra2 = 5'd31; s.wreg = 1'b1; s.wd = 5'd4;
    s.wdata = 32'h4444;
    apply(s);
    for (int i = 0; i < 32; i++) begin
      s = bubble(); s.re1 = 1'b1; s.ra1 = 5'(i);
      s.re2 = 1'b1; s.ra2 = 5'(i ^ 5'h1F);
      apply(s);
    end
    for (int i = 0; i < 20 && expq.size() != 0; i++)
      @(posedge cpu_clk_75M);
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain act=%0d exp=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
